// File: rtl/conv_pkg.sv
// conv_pkg: shared state type, kernel size and accumulator sizing for the 3x3 stream convolver
package conv_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
    localparam int KSIZE = 3;
    function automatic int acc_width(input int pw, input int ww);
        return pw + ww + 4;
    endfunction
endpackage

// File: rtl/conv3x3_mac.sv
// conv3x3_mac: combinational 9-tap multiply-add, unsigned pixels times signed weights
module conv3x3_mac
    import conv_pkg::*;
#(
    parameter int PW    = 2,
    parameter int WW    = 3,
    parameter int OUT_W = acc_width(PW, WW)
) (
    input  logic [KSIZE-1:0][KSIZE-1:0][PW-1:0] win,
    input  logic [KSIZE-1:0][KSIZE-1:0][WW-1:0] k,
    output logic signed [OUT_W-1:0]             sum
);
    always_comb begin
        sum = '0;
        for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++)
                sum = sum + $signed({{(OUT_W-PW){1'b0}}, win[i][j]})
                          * $signed({{(OUT_W-WW){k[i][j][WW-1]}}, k[i][j]});
    end
endmodule

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: raster-order streaming 3x3 convolution with two line buffers.
// Define CONV3X3_RELU_EN to clamp negative sums to zero before the output register.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int IMG_W = 12,
    parameter int IMG_H = 12,
    parameter int PW    = 2,
    parameter int WW    = 3,
    parameter int OUT_W = acc_width(PW, WW)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    w_load,
    input  logic [9*WW-1:0]         w_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PW-1:0]           in_pix,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t                                     state;
    logic [CW-1:0]                              col;
    logic [RW-1:0]                              row;
    logic [KSIZE-1:0][KSIZE-1:0][WW-1:0]        k;
    logic [PW-1:0]                              lb0 [IMG_W];
    logic [PW-1:0]                              lb1 [IMG_W];
    // Only the two older window columns are stored; the newest is formed from the incoming pixel
    logic [KSIZE-1:0][KSIZE-2:0][PW-1:0]        win;
    logic [KSIZE-1:0][KSIZE-1:0][PW-1:0]        tap;
    logic signed [OUT_W-1:0]                    sum;
    logic signed [OUT_W-1:0]                    res;
    logic                                       accept;
    logic                                       emit;
    logic                                       last_px;

    assign in_ready   = (state != DRAIN) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign last_px    = (row == ROW_LAST) && (col == COL_LAST);
    assign emit       = accept && (row >= RW'(2)) && (col >= CW'(2));
    assign busy       = state != IDLE;
    assign frame_done = (state == DRAIN) && out_valid && out_ready && out_last;

    assign tap[0] = {lb1[col], win[0]};
    assign tap[1] = {lb0[col], win[1]};
    assign tap[2] = {in_pix,   win[2]};

    conv3x3_mac #(.PW(PW), .WW(WW), .OUT_W(OUT_W)) u_mac (
        .win (tap),
        .k   (k),
        .sum (sum)
    );

`ifdef CONV3X3_RELU_EN
    assign res = sum[OUT_W-1] ? '0 : sum;
`else
    assign res = sum;
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= in_pix;
            for (int i = 0; i < KSIZE; i++)
                win[i] <= tap[i][KSIZE-1:1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (state == IDLE && w_load)
                k <= w_data;
            if (accept) begin
                col <= (col == COL_LAST) ? '0 : col + CW'(1);
                row <= (col != COL_LAST) ? row : (row == ROW_LAST) ? '0 : row + RW'(1);
            end
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= res;
                out_last  <= last_px;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            state <= (state == IDLE && accept)              ? ACTIVE :
                     (state == ACTIVE && accept && last_px) ? DRAIN  :
                     (state == DRAIN && frame_done)         ? IDLE   : state;
        end
    end
endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: scoreboard bench for conv3x3_stream (weights, backpressure, weight lock, reset)
module tb_conv3x3_stream;
    localparam int W  = 12;
    localparam int H  = 12;
    localparam int PW = 2;
    localparam int WW = 3;
    localparam int OW = PW + WW + 4;

    typedef struct {longint data; bit last;} exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 w_load = 1'b0;
    logic [9*WW-1:0]      w_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [PW-1:0]        in_pix = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [OW-1:0] out_data;
    logic                 out_last;
    logic                 busy;
    logic                 frame_done;

    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    exp_t e;
    int   img[H][W];
    int   fw[3][3];
    int   tcol = 0, trow = 0, nres = 0, frames = 0, bp_left = 0;

    int zero_k[3][3]  = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
    int ident_k[3][3] = '{'{0, 0, 0}, '{0, 1, 0}, '{0, 0, 0}};
    int ones_k[3][3]  = '{'{1, 1, 1}, '{1, 1, 1}, '{1, 1, 1}};
    int neg_k[3][3]   = '{'{-4, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
    int a_k[3][3]     = '{'{1, -2, 3}, '{-4, 0, 2}, '{-1, 1, 3}};
    int b_k[3][3]     = '{'{-1, 2, 0}, '{3, -3, 1}, '{0, 2, -2}};

    conv3x3_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .w_load     (w_load),
        .w_data     (w_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pix     (in_pix),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic logic [9*WW-1:0] pack(input int kk[3][3]);
        logic [9*WW-1:0] p;
        p = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[(i*3+j)*WW +: WW] = WW'(kk[i][j]);
        return p;
    endfunction

    // Scoreboard: push on each completing pixel accept, pop on each result accept
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            tcol = 0;
            trow = 0;
            nres = 0;
        end else begin
            if (out_valid && !out_ready) begin
                check("stall_in_ready", in_ready, 0);
                if (q.size() > 0) check("hold_data", out_data, q[0].data);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("extra_result", 1, 0);
                else begin
                    e = q.pop_front();
                    nres++;
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                    check("frame_done", frame_done, e.last);
                    if (e.last) begin
                        check("result_count", nres, (H-2)*(W-2));
                        nres = 0;
                        frames++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (trow >= 2 && tcol >= 2) begin
                    longint s;
                    s = 0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            s += fw[i][j] * img[trow-2+i][tcol-2+j];
`ifdef CONV3X3_RELU_EN
                    if (s < 0) s = 0;
`endif
                    q.push_back('{s, (trow == H-1 && tcol == W-1)});
                end
                if (tcol == W-1) begin
                    tcol = 0;
                    trow = (trow == H-1) ? 0 : trow + 1;
                end else tcol++;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (bp_left > 0) begin
            out_ready = 1'b0;
            bp_left--;
        end else out_ready = 1'b1;
    end

    task automatic chk_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_in_ready", in_ready, 1);
    endtask

    task automatic load_idle(input int kk[3][3]);
        w_load = 1'b1;
        w_data = pack(kk);
        fw = kk;
        @(posedge clk);
        #1;
        w_load = 1'b0;
    endtask

    task automatic wait_acc();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_img(input int mode);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (mode == 0) ? int'($urandom_range(0, 3)) : 3;
    endtask

    task automatic send_pixels(input int npix, input int ld_at, input int kk[3][3], input int bp_at);
        if (ld_at == 0) fw = kk;
        for (int p = 0; p < npix; p++) begin
            in_valid = 1'b1;
            in_pix   = PW'(img[p/W][p%W]);
            w_load   = (p == ld_at);
            w_data   = pack(kk);
            if (p == bp_at) bp_left = 5;
            wait_acc();
            if (p == 70) check("busy_mid", busy, 1);
        end
        in_valid = 1'b0;
        w_load   = 1'b0;
    endtask

    task automatic run_frame(input int mode, input int ld_at, input int kk[3][3], input int bp_at);
        int f0;
        int n;
        f0 = frames;
        n = 0;
        fill_img(mode);
        send_pixels(W*H, ld_at, kk, bp_at);
        while (frames == f0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("frame_end", frames, f0 + 1);
        @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 1);
    endtask

    initial begin
        fw = zero_k;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(0, -1, zero_k, -1);
        load_idle(ident_k);
        run_frame(0, -1, zero_k, -1);
        load_idle(ones_k);
        run_frame(1, -1, zero_k, -1);
        load_idle(neg_k);
        run_frame(1, -1, zero_k, -1);
        load_idle(a_k);
        run_frame(0, -1, zero_k, 60);
        run_frame(0, 30, b_k, -1);
        load_idle(b_k);
        run_frame(0, -1, zero_k, -1);
        run_frame(0, 0, ident_k, -1);
        load_idle(ones_k);
        fill_img(0);
        send_pixels(40, -1, zero_k, -1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fw = zero_k;
        load_idle(a_k);
        run_frame(0, -1, zero_k, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
